// File: rtl/mem_ctrl_pkg.sv
// Shared types for the queued CPU-to-DDR memory controller.
// Default widths match the controller's default parameters.
package mem_ctrl_pkg;

    localparam int MC_ADDR_WIDTH = 10;
    localparam int MC_DATA_WIDTH = 32;
    localparam int MC_BE_WIDTH   = MC_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic                     we;
        logic [MC_ADDR_WIDTH-1:0] addr;
        logic [MC_DATA_WIDTH-1:0] wdata;
        logic [MC_BE_WIDTH-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request queue, no fall-through.
// Pointers carry an extra wrap bit to tell full from empty.
module mem_req_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = mem_req_t
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mem_ctrl_queued.sv
// Queued CPU-to-DDR controller: one DDR command outstanding,
// responses returned strictly in request order.
module mem_ctrl_queued
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = MC_ADDR_WIDTH,
    parameter int DATA_WIDTH = MC_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic                    cpu_req_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_req_be,
    output logic                    cpu_rsp_valid,
    input  logic                    cpu_rsp_ready,
    output logic                    cpu_rsp_we,
    output logic [DATA_WIDTH-1:0]   cpu_rsp_rdata,
    output logic                    cpu_rsp_err,
    output logic                    ddr_wr_req,
    output logic                    ddr_rd_req,
    output logic [ADDR_WIDTH-1:0]   ddr_addr,
    output logic [DATA_WIDTH-1:0]   ddr_wr_data,
    output logic [DATA_WIDTH/8-1:0] ddr_wr_be,
    input  logic                    ddr_ready,
    input  logic [DATA_WIDTH-1:0]   ddr_rd_data,
    input  logic                    ddr_rd_valid,
    output logic                    busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int TW = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } req_t;

    state_t              state;
    state_t              state_nxt;
    req_t                push_req;
    req_t                head;
    req_t                cmd;
    logic                full;
    logic                empty;
    logic                pop;
    logic                timeout;
    logic                issue;
    logic [TW-1:0]       timer;
    logic                rsp_we;
    logic                rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    assign push_req = '{
        we:    cpu_req_we,
        addr:  cpu_req_addr,
        wdata: cpu_req_wdata,
        be:    cpu_req_be
    };

    mem_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cpu_req_valid),
        .wdata   (push_req),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    generate
        if (RD_TIMEOUT > 0) begin : g_tmo
            assign timeout = (timer == TW'(RD_TIMEOUT - 1));
        end else begin : g_no_tmo
            assign timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ddr_ready) begin
                    state_nxt = cmd.we ? ST_RESP : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (ddr_rd_valid || timeout) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cpu_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read data beats the timeout when both land in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            timer     <= '0;
            rsp_we    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cmd <= head;
            end
            case (state)
                ST_ISSUE: begin
                    if (ddr_ready) begin
                        timer     <= '0;
                        rsp_we    <= cmd.we;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                ST_RD_WAIT: begin
                    if (ddr_rd_valid) begin
                        rsp_rdata <= ddr_rd_data;
                        rsp_err   <= 1'b0;
                    end else if (timeout) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (cpu_rsp_ready) begin
                        rsp_we    <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign issue         = (state == ST_ISSUE);
    assign cpu_req_ready = !full;
    assign cpu_rsp_valid = (state == ST_RESP);
    assign cpu_rsp_we    = rsp_we;
    assign cpu_rsp_err   = rsp_err;
    assign cpu_rsp_rdata = rsp_rdata;
    assign ddr_wr_req    = issue && cmd.we;
    assign ddr_rd_req    = issue && !cmd.we;
    assign ddr_addr      = issue ? cmd.addr : '0;
    assign ddr_wr_data   = ddr_wr_req ? cmd.wdata : '0;
    assign ddr_wr_be     = ddr_wr_req ? cmd.be : '0;
    assign busy          = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_mem_ctrl_queued.sv
// Bench for mem_ctrl_queued: directed scenarios plus a randomized run
// scored against an in-order memory reference model.
module tb_mem_ctrl_queued;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic          cpu_req_we;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic [BW-1:0] cpu_req_be;
    logic          cpu_rsp_valid;
    logic          cpu_rsp_ready;
    logic          cpu_rsp_we;
    logic [DW-1:0] cpu_rsp_rdata;
    logic          cpu_rsp_err;
    logic          ddr_wr_req;
    logic          ddr_rd_req;
    logic [AW-1:0] ddr_addr;
    logic [DW-1:0] ddr_wr_data;
    logic [BW-1:0] ddr_wr_be;
    logic          ddr_ready;
    logic [DW-1:0] ddr_rd_data;
    logic          ddr_rd_valid;
    logic          busy;

    mem_ctrl_queued #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .RD_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_req_be    (cpu_req_be),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_ready (cpu_rsp_ready),
        .cpu_rsp_we    (cpu_rsp_we),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .cpu_rsp_err   (cpu_rsp_err),
        .ddr_wr_req    (ddr_wr_req),
        .ddr_rd_req    (ddr_rd_req),
        .ddr_addr      (ddr_addr),
        .ddr_wr_data   (ddr_wr_data),
        .ddr_wr_be     (ddr_wr_be),
        .ddr_ready     (ddr_ready),
        .ddr_rd_data   (ddr_rd_data),
        .ddr_rd_valid  (ddr_rd_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          we;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ddr_mem [int];
    bit            next_timeout = 1'b0;
    int            n_rsp = 0;

    function automatic logic [DW-1:0] init_val(int a);
        return 32'hA500_0000 ^ (32'(a) * 32'h0001_0203);
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old_v,
                                            logic [DW-1:0] new_v,
                                            logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    // DDR model: either random backpressure and read latency, or
    // driven directly by the directed steps through man_* controls.
    bit            ddr_auto = 1'b0;
    logic          man_ready = 1'b0;
    logic          man_rd_valid = 1'b0;
    logic [DW-1:0] man_rd_data = '0;
    int            wr_acc = 0;
    int            rd_acc = 0;
    int            rd_cnt = 0;
    logic [DW-1:0] rd_val = '0;

    always @(negedge clk) begin
        ddr_rd_valid = 1'b0;
        ddr_rd_data  = '0;
        if (!reset_n) rd_cnt = 0;
        if (ddr_auto) begin
            ddr_ready = ($urandom_range(0, 3) != 0);
            if (rd_cnt != 0) begin
                rd_cnt = rd_cnt - 1;
                if (rd_cnt == 0) begin
                    ddr_rd_valid = 1'b1;
                    ddr_rd_data  = rd_val;
                end
            end
        end else begin
            ddr_ready    = man_ready;
            ddr_rd_valid = man_rd_valid;
            ddr_rd_data  = man_rd_data;
        end
        if (ddr_ready && ddr_wr_req) begin
            ddr_mem[int'(ddr_addr)] = merge(
                ddr_mem.exists(int'(ddr_addr)) ? ddr_mem[int'(ddr_addr)]
                                               : init_val(int'(ddr_addr)),
                ddr_wr_data, ddr_wr_be);
            wr_acc = wr_acc + 1;
        end
        if (ddr_ready && ddr_rd_req) begin
            rd_val = ddr_mem.exists(int'(ddr_addr)) ? ddr_mem[int'(ddr_addr)]
                                                    : init_val(int'(ddr_addr));
            rd_cnt = int'($urandom_range(1, 6));
            rd_acc = rd_acc + 1;
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_push();
        rsp_t          r;
        logic [DW-1:0] cur;
        int            a;
        a       = int'(cpu_req_addr);
        cur     = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        r.we    = cpu_req_we;
        r.err   = 1'b0;
        r.rdata = '0;
        if (cpu_req_we) begin
            ref_mem[a] = merge(cur, cpu_req_wdata, cpu_req_be);
        end else if (next_timeout) begin
            r.err        = 1'b1;
            next_timeout = 1'b0;
        end else begin
            r.rdata = cur;
        end
        exp_q.push_back(r);
    endtask

    // Scores the handshakes of the current cycle, then advances one cycle.
    task automatic tick();
        rsp_t e;
        if (cpu_req_valid && cpu_req_ready) ref_push();
        if (cpu_rsp_valid && cpu_rsp_ready) begin
            chk("rsp_in_queue", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_we", 64'(cpu_rsp_we), 64'(e.we));
                chk("rsp_rdata", 64'(cpu_rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(cpu_rsp_err), 64'(e.err));
                n_rsp++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(logic we, logic [AW-1:0] a,
                           logic [DW-1:0] d, logic [BW-1:0] be);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = a;
        cpu_req_wdata = d;
        cpu_req_be    = be;
    endtask

    initial begin
        int acc_cyc;
        int lat;
        int pushed;
        int n0;
        int wacc0;
        bit found;

        reset_n       = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        cpu_req_be    = '0;
        cpu_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_req_ready", 64'(cpu_req_ready), 64'(1));
        chk("rst_rsp_valid", 64'(cpu_rsp_valid), 64'(0));
        chk("rst_ddr_req", 64'({ddr_wr_req, ddr_rd_req}), 64'(0));
        chk("rst_ddr_addr", 64'(ddr_addr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        reset_n = 1'b1;
        tick();

        // Write with immediate DDR accept
        man_ready     = 1'b1;
        cpu_rsp_ready = 1'b1;
        set_req(1'b1, 10'h012, 32'hDEAD_BEEF, 4'hF);
        tick();
        cpu_req_valid = 1'b0;
        chk("t1_no_early_cmd", 64'(ddr_wr_req), 64'(0));
        tick();
        chk("t1_wr_req", 64'(ddr_wr_req), 64'(1));
        chk("t1_rd_req", 64'(ddr_rd_req), 64'(0));
        chk("t1_addr", 64'(ddr_addr), 64'(10'h012));
        chk("t1_wdata", 64'(ddr_wr_data), 64'(32'hDEAD_BEEF));
        chk("t1_be", 64'(ddr_wr_be), 64'(4'hF));
        chk("t1_rsp_early", 64'(cpu_rsp_valid), 64'(0));
        tick();
        chk("t1_rsp_valid", 64'(cpu_rsp_valid), 64'(1));
        chk("t1_rsp_we", 64'(cpu_rsp_we), 64'(1));
        chk("t1_rsp_err", 64'(cpu_rsp_err), 64'(0));
        chk("t1_rsp_rdata", 64'(cpu_rsp_rdata), 64'(0));
        tick();
        chk("t1_rsp_done", 64'(cpu_rsp_valid), 64'(0));
        chk("t1_idle", 64'(busy), 64'(0));

        // Read with data 3 cycles after accept
        set_req(1'b0, 10'h012, '0, '0);
        tick();
        cpu_req_valid = 1'b0;
        tick();
        chk("t2_rd_req", 64'(ddr_rd_req), 64'(1));
        chk("t2_addr", 64'(ddr_addr), 64'(10'h012));
        chk("t2_no_wdata", 64'({ddr_wr_data, ddr_wr_be}), 64'(0));
        tick();
        chk("t2_addr_idle", 64'(ddr_addr), 64'(0));
        tick();
        tick();
        man_rd_valid = 1'b1;
        man_rd_data  = 32'hDEAD_BEEF;
        chk("t2_rsp_early", 64'(cpu_rsp_valid), 64'(0));
        tick();
        man_rd_valid = 1'b0;
        man_rd_data  = '0;
        chk("t2_rsp_valid", 64'(cpu_rsp_valid), 64'(1));
        chk("t2_rsp_we", 64'(cpu_rsp_we), 64'(0));
        chk("t2_rsp_rdata", 64'(cpu_rsp_rdata), 64'(32'hDEAD_BEEF));
        chk("t2_rsp_err", 64'(cpu_rsp_err), 64'(0));
        tick();

        // DDR backpressure: command held stable, accepted exactly once
        man_ready = 1'b0;
        wacc0     = wr_acc;
        set_req(1'b1, 10'h055, 32'h1357_9BDF, 4'h5);
        tick();
        cpu_req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_req", 64'(ddr_wr_req), 64'(1));
            chk("t3_hold_addr", 64'(ddr_addr), 64'(10'h055));
            chk("t3_hold_data", 64'(ddr_wr_data), 64'(32'h1357_9BDF));
            chk("t3_hold_be", 64'(ddr_wr_be), 64'(4'h5));
            tick();
        end
        man_ready = 1'b1;
        chk("t3_still_req", 64'(ddr_wr_req), 64'(1));
        tick();
        chk("t3_rsp_valid", 64'(cpu_rsp_valid), 64'(1));
        chk("t3_one_accept", 64'(wr_acc - wacc0), 64'(1));
        tick();
        tick();
        chk("t3_one_accept_after", 64'(wr_acc - wacc0), 64'(1));
        chk("t3_no_req", 64'(ddr_wr_req), 64'(0));

        // Queue fills while responses are stalled
        ddr_auto      = 1'b1;
        cpu_rsp_ready = 1'b0;
        pushed        = 0;
        n0            = n_rsp;
        for (int i = 0; i < 12; i++) begin
            set_req(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
                    $urandom, 4'($urandom_range(0, 15)));
            if (cpu_req_ready) pushed++;
            tick();
        end
        chk("t4_accepted", 64'(pushed), 64'(5));
        chk("t4_ready_low", 64'(cpu_req_ready), 64'(0));
        chk("t4_busy", 64'(busy), 64'(1));
        cpu_req_valid = 1'b0;
        cpu_rsp_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
        chk("t4_rsp_count", 64'(n_rsp - n0), 64'(5));

        // Read timeout, then a late rd_valid that must be ignored
        ddr_auto      = 1'b0;
        man_ready     = 1'b1;
        cpu_rsp_ready = 1'b0;
        next_timeout  = 1'b1;
        set_req(1'b0, 10'h030, '0, '0);
        tick();
        cpu_req_valid = 1'b0;
        tick();
        chk("t5_rd_req", 64'(ddr_rd_req), 64'(1));
        acc_cyc = cyc;
        found   = 1'b0;
        lat     = 0;
        for (int i = 0; i < 120 && !found; i++) begin
            tick();
            if (cpu_rsp_valid) begin
                found = 1'b1;
                lat   = cyc - acc_cyc;
            end
        end
        chk("t5_timeout_seen", 64'(found), 64'(1));
        chk("t5_latency", 64'(lat), 64'(TMO + 1));
        man_rd_valid = 1'b1;
        man_rd_data  = 32'hBAD0_BAD0;
        tick();
        man_rd_valid = 1'b0;
        man_rd_data  = '0;
        chk("t5_rsp_err", 64'(cpu_rsp_err), 64'(1));
        chk("t5_rsp_rdata", 64'(cpu_rsp_rdata), 64'(0));
        cpu_rsp_ready = 1'b1;
        tick();
        tick();
        chk("t5_idle", 64'(busy), 64'(0));

        // Reset during RD_WAIT with two requests queued
        set_req(1'b0, 10'h040, '0, '0);
        tick();
        cpu_req_addr = 10'h041;
        tick();
        cpu_req_addr = 10'h042;
        tick();
        cpu_req_valid = 1'b0;
        tick();
        chk("t6_busy_before", 64'(busy), 64'(1));
        chk("t6_waiting", 64'(cpu_rsp_valid), 64'(0));
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_req_ready", 64'(cpu_req_ready), 64'(1));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_rsp", 64'({cpu_rsp_valid, cpu_rsp_we, cpu_rsp_err}), 64'(0));
        chk("t6_rsp_rdata", 64'(cpu_rsp_rdata), 64'(0));
        chk("t6_ddr_req", 64'({ddr_wr_req, ddr_rd_req}), 64'(0));
        chk("t6_ddr_bus", 64'({ddr_addr, ddr_wr_data, ddr_wr_be}), 64'(0));
        tick();
        reset_n      = 1'b1;
        man_rd_valid = 1'b1;
        man_rd_data  = 32'h0BAD_F00D;
        tick();
        man_rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_quiet_rsp", 64'(cpu_rsp_valid), 64'(0));
            chk("t6_quiet_busy", 64'(busy), 64'(0));
        end

        // Randomized traffic against the reference model
        ddr_auto = 1'b1;
        for (int i = 0; i < 400; i++) begin
            set_req(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
                    $urandom, 4'($urandom_range(0, 15)));
            cpu_req_valid = ($urandom_range(0, 1) == 1);
            cpu_rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        cpu_req_valid = 1'b0;
        cpu_rsp_ready = 1'b1;
        for (int i = 0; i < 500 && exp_q.size() > 0; i++) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'(0));
        tick();
        chk("rand_idle", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
